// File: rtl/alu_pkg.sv
// Shared ALU definitions: ARM data-processing opcodes and the pipeline FSM encoding.
// Pure declarations; no logic, latency or flow control of its own.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_RSB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_RSC = 4'b0111;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_BIC = 4'b1110;
  localparam logic [3:0] OP_MVN = 4'b1111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // TST/TEQ/CMP/CMN: flag-only ops, never written back, always update NZCV.
  function automatic logic is_test_op(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, low WIDTH bits of the product, one bit per cycle.
// Latency WIDTH cycles after start; done is combinational in the last cycle with product valid.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic             busy;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;

  // Product of the current step; on the final step this is the full result.
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = busy && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      cnt    <= '0;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// ARM-style ALU with NZCV flags: 1-cycle latency for data ops, WIDTH+1 cycles for MUL.
// Valid/ready both sides; in_ready drops while the output is stalled or a MUL is running.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       control,
  input  logic             mul,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_write,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             is_mul;
  logic [3:0]       eff_op;
  logic             mul_sf;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic             arith;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  assign is_mul   = mul && (MUL_EN != 0);
  // Without a multiplier a MUL request degrades to MOV.
  assign eff_op   = mul ? OP_MOV : control;
  assign in_ready = !rst && (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  generate
    if (MUL_EN != 0) begin : g_mul
      alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (operand1),
        .b       (operand2),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : g_no_mul
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  // Subtractions are x + ~y + cin so C comes out as NOT borrow.
  always_comb begin
    add_x   = operand1;
    add_y   = operand2;
    add_cin = 1'b0;
    arith   = 1'b0;
    alu_res = '0;
    case (eff_op)
      OP_AND, OP_TST: alu_res = operand1 & operand2;
      OP_EOR, OP_TEQ: alu_res = operand1 ^ operand2;
      OP_SUB, OP_CMP: begin add_y = ~operand2; add_cin = 1'b1; arith = 1'b1; end
      OP_RSB:         begin add_x = operand2; add_y = ~operand1; add_cin = 1'b1; arith = 1'b1; end
      OP_ADD, OP_CMN: arith = 1'b1;
      OP_ADC:         begin add_cin = flag_c; arith = 1'b1; end
      OP_SBC:         begin add_y = ~operand2; add_cin = flag_c; arith = 1'b1; end
      OP_RSC:         begin add_x = operand2; add_y = ~operand1; add_cin = flag_c; arith = 1'b1; end
      OP_ORR:         alu_res = operand1 | operand2;
      OP_MOV:         alu_res = operand2;
      OP_BIC:         alu_res = operand1 & ~operand2;
      OP_MVN:         alu_res = ~operand2;
      default:        alu_res = '0;
    endcase
    if (arith) begin
      alu_res = add_sum[WIDTH-1:0];
    end
  end

  assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
  assign alu_c   = arith ? add_sum[WIDTH] : flag_c;
  assign alu_v   = arith ? ((add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                            (add_sum[WIDTH-1] != add_x[WIDTH-1])) : flag_v;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && is_mul) state_nxt = ST_MUL;
      ST_MUL:  if (mul_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_write <= 1'b0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      mul_sf    <= 1'b0;
    end else begin
      if (state == ST_MUL) begin
        // out_valid is already low here: entering MUL required a free output.
        if (mul_done) begin
          out_valid <= 1'b1;
          out_data  <= mul_product;
          out_write <= 1'b1;
          if (mul_sf) begin
            flag_n <= mul_product[WIDTH-1];
            flag_z <= (mul_product == '0);
          end
        end
      end else if (accept && !is_mul) begin
        out_valid <= 1'b1;
        out_data  <= alu_res;
        out_write <= !is_test_op(eff_op);
        if (set_flags || is_test_op(eff_op)) begin
          flag_n <= alu_res[WIDTH-1];
          flag_z <= (alu_res == '0);
          flag_c <= alu_c;
          flag_v <= alu_v;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && is_mul) begin
        mul_sf <= set_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe at WIDTH=32.
module tb_alu_pipe;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  control;
  logic        mul;
  logic        set_flags;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_write;
  logic        flag_n, flag_z, flag_c, flag_v;

  int checks   = 0;
  int failures = 0;
  int cnt;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(32), .MUL_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .control   (control),
    .mul       (mul),
    .set_flags (set_flags),
    .operand1  (operand1),
    .operand2  (operand2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_write (out_write),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic req(input logic [3:0] op, input logic m, input logic sf,
                     input logic [31:0] a, input logic [31:0] b);
    in_valid  = 1'b1;
    control   = op;
    mul       = m;
    set_flags = sf;
    operand1  = a;
    operand2  = b;
  endtask

  function automatic logic [3:0] nzcv();
    return {flag_n, flag_z, flag_c, flag_v};
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    control = OP_AND; mul = 1'b0; set_flags = 1'b0;
    operand1 = '0; operand2 = '0;

    // Reset state
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data), 64'd0);
    chk("rst_out_write", 64'(out_write), 64'd0);
    chk("rst_nzcv",      64'(nzcv()), 64'b0000);
    chk("rst_in_ready",  64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // ADD 1 + 0xA
    req(OP_ADD, 1'b0, 1'b0, 32'h1, 32'hA);
    tick();
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_data",  64'(out_data), 64'h0000000B);
    chk("add_write", 64'(out_write), 64'd1);
    chk("add_nzcv",  64'(nzcv()), 64'b0000);

    // ADDS wraps to zero with carry, then ADC back-to-back consumes C
    req(OP_ADD, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h1);
    tick();
    chk("adds_data", 64'(out_data), 64'd0);
    chk("adds_nzcv", 64'(nzcv()), 64'b0110);
    req(OP_ADC, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("adc_data",  64'(out_data), 64'h1);
    chk("adc_nzcv",  64'(nzcv()), 64'b0110);

    // CMP updates flags even with set_flags low, and is not written back
    req(OP_CMP, 1'b0, 1'b0, 32'h80000000, 32'h1);
    tick();
    chk("cmp_data",  64'(out_data), 64'h7FFFFFFF);
    chk("cmp_write", 64'(out_write), 64'd0);
    chk("cmp_nzcv",  64'(nzcv()), 64'b0011);

    // MULS: 32 busy cycles, operands scrambled after acceptance
    req(OP_AND, 1'b1, 1'b1, 32'h0000FFFF, 32'h00010001);
    tick();
    in_valid = 1'b0; mul = 1'b0; operand1 = 32'hDEADBEEF; operand2 = 32'h12345678;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      #1;
      if (!in_ready && !out_valid) cnt++;
      tick();
    end
    chk("mul_busy_cycles", 64'(cnt), 64'd32);
    chk("mul_valid", 64'(out_valid), 64'd1);
    chk("mul_data",  64'(out_data), 64'hFFFFFFFF);
    chk("mul_write", 64'(out_write), 64'd1);
    chk("mul_nzcv",  64'(nzcv()), 64'b1011);

    // Backpressure for 5 cycles with a new request waiting
    out_ready = 1'b0;
    req(OP_ADD, 1'b0, 1'b0, 32'h2, 32'h3);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (!in_ready && out_valid && out_data == 32'hFFFFFFFF && out_write) cnt++;
      tick();
    end
    chk("stall_cycles", 64'(cnt), 64'd5);
    chk("stall_data",   64'(out_data), 64'hFFFFFFFF);
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("release_valid", 64'(out_valid), 64'd1);
    chk("release_data",  64'(out_data), 64'h5);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 64'(out_valid), 64'd0);

    // Reset during MUL cycle 10 aborts the multiply
    req(OP_AND, 1'b1, 1'b1, 32'h3, 32'h5);
    tick();
    in_valid = 1'b0; mul = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    chk("abort_valid",    64'(out_valid), 64'd0);
    chk("abort_nzcv",     64'(nzcv()), 64'b0000);
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("abort_release_in_ready", 64'(in_ready), 64'd1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) cnt++;
    end
    chk("abort_no_result", 64'(cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
